// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decoded instruction for execute,
// resolves its destination register, detects load-use hazards and counts
// load-use stall cycles.
module id_ex_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LINK_REG = 31
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [19:0]       i_ctrl,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_pc_plus4,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [4:0]        i_sa,
    input  logic              i_uses_rs,
    input  logic              i_uses_rt,
    input  logic              i_flush,
    input  logic              i_ex_stall,
    input  logic              i_cnt_clr,
    output logic              o_valid,
    output logic [19:0]       o_ctrl,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_imm,
    output logic [DATA_W-1:0] o_pc_plus4,
    output logic [REG_W-1:0]  o_rs,
    output logic [REG_W-1:0]  o_rt,
    output logic [4:0]        o_sa,
    output logic [REG_W-1:0]  o_dst_reg,
    output logic              o_stall_id,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_HOLD,
        ACT_BUBBLE_FLUSH,
        ACT_BUBBLE_HAZARD
    } action_e;

    logic              r_valid;
    logic [19:0]       r_ctrl;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [4:0]        r_sa;
    logic [REG_W-1:0]  r_dst_reg;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [REG_W-1:0]  w_dst_sel;
    logic              w_src_match;
    logic              w_hazard;
    action_e           w_action;

    // Destination index chosen by the ALU_dst field of the incoming control word
    always_comb begin
        w_dst_sel = '0;
        case (i_ctrl[16:15])
            2'b00:   w_dst_sel = i_rt;
            2'b01:   w_dst_sel = i_rd;
            2'b11:   w_dst_sel = REG_W'(LINK_REG);
            default: w_dst_sel = '0;
        endcase
    end

    // Load in EX whose result a valid decode instruction needs right now
    always_comb begin
        w_src_match = (i_uses_rs && (i_rs == r_dst_reg)) ||
                      (i_uses_rt && (i_rt == r_dst_reg));
        w_hazard    = r_valid && r_ctrl[0] && (r_dst_reg != '0) &&
                      i_valid && w_src_match;
    end

    // Per-edge action: flush beats downstream stall beats load-use bubble
    always_comb begin
        w_action = ACT_CAPTURE;
        if (i_flush)
            w_action = ACT_BUBBLE_FLUSH;
        else if (i_ex_stall)
            w_action = ACT_HOLD;
        else if (w_hazard)
            w_action = ACT_BUBBLE_HAZARD;
    end

    assign o_stall_id = (w_hazard || i_ex_stall) && !i_flush;

    // Pipeline register: bubble, hold or capture the decode slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_pc_plus4 <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_sa       <= '0;
            r_dst_reg  <= '0;
        end else begin
            case (w_action)
                ACT_BUBBLE_FLUSH, ACT_BUBBLE_HAZARD: begin
                    r_valid    <= 1'b0;
                    r_ctrl     <= '0;
                    r_rs_data  <= '0;
                    r_rt_data  <= '0;
                    r_imm      <= '0;
                    r_pc_plus4 <= '0;
                    r_rs       <= '0;
                    r_rt       <= '0;
                    r_sa       <= '0;
                    r_dst_reg  <= '0;
                end
                ACT_CAPTURE: begin
                    r_valid    <= i_valid;
                    r_ctrl     <= i_valid ? i_ctrl : '0;
                    r_rs_data  <= i_rs_data;
                    r_rt_data  <= i_rt_data;
                    r_imm      <= i_imm;
                    r_pc_plus4 <= i_pc_plus4;
                    r_rs       <= i_rs;
                    r_rt       <= i_rt;
                    r_sa       <= i_sa;
                    r_dst_reg  <= i_valid ? w_dst_sel : '0;
                end
                default: ;
            endcase
        end
    end

    // Saturating load-use stall counter; clear wins over increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_stall_cnt <= '0;
        else if (i_cnt_clr)
            r_stall_cnt <= '0;
        else if ((w_action == ACT_BUBBLE_HAZARD) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign o_valid     = r_valid;
    assign o_ctrl      = r_ctrl;
    assign o_rs_data   = r_rs_data;
    assign o_rt_data   = r_rt_data;
    assign o_imm       = r_imm;
    assign o_pc_plus4  = r_pc_plus4;
    assign o_rs        = r_rs;
    assign o_rt        = r_rt;
    assign o_sa        = r_sa;
    assign o_dst_reg   = r_dst_reg;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
// A second instance with a 2-bit counter shares the stimulus to show saturation.
module tb_id_ex_stage;

    localparam logic [19:0] C_LW = 20'h00003;  // ALU_dst=00, mem_op, mem_read
    localparam logic [19:0] C_RT = 20'h09000;  // ALU_dst=01, ALU_opcode=2

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_uses_rs, i_uses_rt, i_flush, i_ex_stall, i_cnt_clr;
    logic [19:0] i_ctrl;
    logic [31:0] i_rs_data, i_rt_data, i_imm, i_pc_plus4;
    logic [4:0]  i_rs, i_rt, i_rd, i_sa;

    logic        o_valid, o_stall_id;
    logic [19:0] o_ctrl;
    logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc_plus4;
    logic [4:0]  o_rs, o_rt, o_sa, o_dst_reg;
    logic [15:0] o_stall_cnt;

    logic        b_valid, b_stall_id;
    logic [19:0] b_ctrl;
    logic [31:0] b_rs_data, b_rt_data, b_imm, b_pc_plus4;
    logic [4:0]  b_rs, b_rt, b_sa, b_dst_reg;
    logic [1:0]  b_stall_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16), .LINK_REG(31)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_ctrl(i_ctrl),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_pc_plus4(i_pc_plus4), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_sa(i_sa), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
        .i_flush(i_flush), .i_ex_stall(i_ex_stall), .i_cnt_clr(i_cnt_clr),
        .o_valid(o_valid), .o_ctrl(o_ctrl), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm(o_imm), .o_pc_plus4(o_pc_plus4),
        .o_rs(o_rs), .o_rt(o_rt), .o_sa(o_sa), .o_dst_reg(o_dst_reg),
        .o_stall_id(o_stall_id), .o_stall_cnt(o_stall_cnt)
    );

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2), .LINK_REG(31)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_ctrl(i_ctrl),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_pc_plus4(i_pc_plus4), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_sa(i_sa), .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
        .i_flush(i_flush), .i_ex_stall(i_ex_stall), .i_cnt_clr(i_cnt_clr),
        .o_valid(b_valid), .o_ctrl(b_ctrl), .o_rs_data(b_rs_data),
        .o_rt_data(b_rt_data), .o_imm(b_imm), .o_pc_plus4(b_pc_plus4),
        .o_rs(b_rs), .o_rt(b_rt), .o_sa(b_sa), .o_dst_reg(b_dst_reg),
        .o_stall_id(b_stall_id), .o_stall_cnt(b_stall_cnt)
    );

    // ---------------- behavioural model of the EX slot ----------------
    bit          m_valid, m_dc;
    logic [19:0] m_ctrl;
    logic [31:0] m_rs_data, m_rt_data, m_imm, m_pc;
    logic [4:0]  m_rs, m_rt, m_sa, m_dst;
    int          m_cnt, m_cnt2;

    function automatic logic [4:0] resolve_dst(logic [1:0] sel, logic [4:0] rt, logic [4:0] rd);
        if (sel == 2'b00) return rt;
        if (sel == 2'b01) return rd;
        if (sel == 2'b11) return 5'd31;
        return 5'd0;
    endfunction

    function automatic bit model_hazard();
        bit reads_it;
        reads_it = (i_uses_rs && i_rs == m_dst) || (i_uses_rt && i_rt == m_dst);
        return m_valid && m_ctrl[0] && (m_dst != 5'd0) && i_valid && reads_it;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_dc <= 0; m_ctrl <= '0; m_dst <= '0;
            m_rs_data <= '0; m_rt_data <= '0; m_imm <= '0; m_pc <= '0;
            m_rs <= '0; m_rt <= '0; m_sa <= '0;
            m_cnt <= 0; m_cnt2 <= 0;
        end else begin
            if (i_flush || (!i_ex_stall && model_hazard())) begin
                m_valid <= 0; m_ctrl <= '0; m_dst <= '0; m_dc <= 1;
            end else if (!i_ex_stall) begin
                m_valid   <= i_valid;
                m_ctrl    <= i_valid ? i_ctrl : 20'd0;
                m_dst     <= i_valid ? resolve_dst(i_ctrl[16:15], i_rt, i_rd) : 5'd0;
                m_rs_data <= i_rs_data; m_rt_data <= i_rt_data;
                m_imm     <= i_imm;     m_pc      <= i_pc_plus4;
                m_rs      <= i_rs;      m_rt      <= i_rt;      m_sa <= i_sa;
                m_dc      <= 0;
            end
            if (i_cnt_clr) begin
                m_cnt <= 0; m_cnt2 <= 0;
            end else if (!i_flush && !i_ex_stall && model_hazard()) begin
                m_cnt  <= (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
                m_cnt2 <= (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every negedge while out of reset
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("m_valid", 64'(o_valid), 64'(m_valid));
            chk("m_ctrl", 64'(o_ctrl), 64'(m_ctrl));
            chk("m_dst", 64'(o_dst_reg), 64'(m_dst));
            chk("m_cnt", 64'(o_stall_cnt), 64'(m_cnt));
            chk("m_cnt2", 64'(b_stall_cnt), 64'(m_cnt2));
            chk("m_stall", 64'(o_stall_id),
                64'((model_hazard() || i_ex_stall) && !i_flush));
            chk("m_stall2", 64'(b_stall_id), 64'(o_stall_id));
            if (!m_dc) begin
                chk("m_rs_data", 64'(o_rs_data), 64'(m_rs_data));
                chk("m_rt_data", 64'(o_rt_data), 64'(m_rt_data));
                chk("m_imm", 64'(o_imm), 64'(m_imm));
                chk("m_pc", 64'(o_pc_plus4), 64'(m_pc));
                chk("m_idx", 64'({o_rs, o_rt, o_sa}), 64'({m_rs, m_rt, m_sa}));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(bit v, logic [19:0] c, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, bit urs, bit urt);
        i_valid = v; i_ctrl = c; i_rs = rs; i_rt = rt; i_rd = rd;
        i_uses_rs = urs; i_uses_rt = urt; i_sa = 5'($urandom);
        i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom; i_pc_plus4 = $urandom;
        i_flush = 0; i_ex_stall = 0; i_cnt_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        drv(0, '0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_cnt", 64'(o_stall_cnt), 0);

        // R-type capture
        drv(1, C_RT, 1, 2, 7, 1, 1);
        #1 chk("rtype_stall", 64'(o_stall_id), 0);
        step();
        chk("rtype_valid", 64'(o_valid), 1);
        chk("rtype_dst", 64'(o_dst_reg), 7);
        chk("rtype_ctrl", 64'(o_ctrl), 64'(C_RT));

        // Load-use: LW r5 then reader of r5
        drv(1, C_LW, 3, 5, 9, 1, 0); step();
        chk("lw_dst", 64'(o_dst_reg), 5);
        drv(1, C_RT, 5, 6, 8, 1, 1);
        #1 chk("lu_stall", 64'(o_stall_id), 1);
        step();
        chk("lu_bubble", 64'(o_valid), 0);
        chk("lu_cnt", 64'(o_stall_cnt), 1);
        chk("lu_stall_gone", 64'(o_stall_id), 0);
        step();
        chk("lu_capture_valid", 64'(o_valid), 1);
        chk("lu_capture_dst", 64'(o_dst_reg), 8);

        // Load to $0 never stalls
        drv(1, C_LW, 3, 0, 9, 1, 0); step();
        drv(1, C_RT, 0, 0, 8, 1, 1);
        #1 chk("z_stall", 64'(o_stall_id), 0);
        step();
        chk("z_valid", 64'(o_valid), 1);
        chk("z_cnt", 64'(o_stall_cnt), 1);

        // Flush beats hazard
        drv(1, C_LW, 3, 5, 9, 1, 0); step();
        drv(1, C_RT, 5, 6, 8, 1, 1); i_flush = 1;
        #1 chk("fl_stall", 64'(o_stall_id), 0);
        step();
        chk("fl_valid", 64'(o_valid), 0);
        chk("fl_ctrl", 64'(o_ctrl), 0);
        chk("fl_cnt", 64'(o_stall_cnt), 1);

        // Downstream stall holds, even with a hazard
        drv(1, C_LW, 3, 5, 9, 1, 0); step();
        drv(1, C_RT, 5, 6, 8, 1, 1); i_ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hs_stall", 64'(o_stall_id), 1);
            step();
            chk("hs_valid", 64'(o_valid), 1);
            chk("hs_dst", 64'(o_dst_reg), 5);
            chk("hs_ctrl", 64'(o_ctrl), 64'(C_LW));
            chk("hs_cnt", 64'(o_stall_cnt), 1);
        end
        i_ex_stall = 0;
        #1 chk("hs_rel_stall", 64'(o_stall_id), 1);
        step();
        chk("hs_rel_valid", 64'(o_valid), 0);
        chk("hs_rel_cnt", 64'(o_stall_cnt), 2);

        // Saturation: 4 hazards on a cleared counter
        drv(0, '0, 0, 0, 0, 0, 0); i_cnt_clr = 1; step();
        chk("clr_cnt", 64'(o_stall_cnt), 0);
        chk("clr_cnt2", 64'(b_stall_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            drv(1, C_LW, 3, 5, 9, 1, 0); step();
            drv(1, C_RT, 1, 5, 8, 0, 1); step();
        end
        chk("sat_cnt16", 64'(o_stall_cnt), 4);
        chk("sat_cnt2", 64'(b_stall_cnt), 3);

        // Asynchronous reset mid-stream
        drv(1, C_RT, 1, 2, 7, 1, 1); step();
        chk("ar_pre_valid", 64'(o_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(o_valid), 0);
        chk("ar_ctrl", 64'(o_ctrl), 0);
        chk("ar_dst", 64'(o_dst_reg), 0);
        chk("ar_cnt", 64'(o_stall_cnt), 0);
        chk("ar_cnt2", 64'(b_stall_cnt), 0);
        step();
        rst_n = 1'b1;

        // Clear wins over a simultaneous hazard increment
        drv(1, C_LW, 3, 5, 9, 1, 0); step();
        drv(1, C_RT, 5, 6, 8, 1, 1); step();
        chk("ch_cnt_pre", 64'(o_stall_cnt), 1);
        drv(1, C_LW, 3, 5, 9, 1, 0); step();
        drv(1, C_RT, 5, 6, 8, 1, 1); i_cnt_clr = 1;
        #1 chk("ch_stall", 64'(o_stall_id), 1);
        step();
        chk("ch_cnt", 64'(o_stall_cnt), 0);
        chk("ch_cnt2", 64'(b_stall_cnt), 0);
        chk("ch_valid", 64'(o_valid), 0);

        // Randomized traffic with small register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            logic [19:0] c;
            c = 20'($urandom);
            c[0] = ($urandom_range(0, 9) < 4);
            drv($urandom_range(0, 9) < 8, c, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
            i_flush    = ($urandom_range(0, 9) == 0);
            i_ex_stall = ($urandom_range(0, 99) < 15);
            i_cnt_clr  = ($urandom_range(0, 99) < 3);
            if (n == 1500) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (instruction decoder plus control unit) and execute.
- Latches the decoded control word, operands and register indices.
- Resolves the destination register index.
- Detects load-use hazards: stalls decode and inserts a bubble.
- Handles flush on taken branch/jump and holds on a downstream stall.
- Keeps a saturating stall-cycle counter.

Parameters:
- DATA_W, 32, operand/immediate/PC width.
- REG_W, 5, register index width.
- CNT_W, 16, stall counter width.
- LINK_REG, 31, destination index when ALU_dst = 11.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  decode slot holds a real instruction.
- i_ctrl  in  20  control word, msb first: [19:18] ALU_src_a, [17] ALU_src_b, [16:15] ALU_dst, [14:11] ALU_opcode, [10] AGU_src_addr, [9] AGU_dst, [8:6] AGU_opcode, [5] jump, [4] branch, [3:2] extend_sign, [1] mem_op, [0] mem_read.
- i_rs_data, i_rt_data  in  DATA_W  register file read data.
- i_imm  in  DATA_W  extended immediate.
- i_pc_plus4  in  DATA_W  PC+4 of the decode instruction.
- i_rs, i_rt, i_rd  in  REG_W  register indices.
- i_sa  in  5  shift amount.
- i_uses_rs, i_uses_rt  in  1  decode instruction reads rs / rt.
- i_flush  in  1  taken branch/jump from EX; kill decode slot.
- i_ex_stall  in  1  execute cannot accept; hold.
- i_cnt_clr  in  1  synchronous clear of the stall counter.
- o_valid  out  1  EX slot valid.
- o_ctrl  out  20  latched control word (zero when bubble).
- o_rs_data, o_rt_data, o_imm, o_pc_plus4  out  DATA_W  latched operands.
- o_rs, o_rt  out  REG_W  latched source indices (for forwarding).
- o_sa  out  5  latched shift amount.
- o_dst_reg  out  REG_W  resolved destination index.
- o_stall_id  out  1  combinational; freeze PC and IF/ID.
- o_stall_cnt  out  CNT_W  load-use stall cycles, saturating.

Behaviour:
- Reset (async, i_rst_n=0): all registered outputs 0; o_valid=0; o_stall_cnt=0. Release takes effect on the next rising edge.
- Destination resolution at capture, from i_ctrl[16:15]:
  - 00 -> i_rt
  - 01 -> i_rd
  - 11 -> LINK_REG
  - 10 -> 0
- Load-use hazard (combinational) requires all of:
  - o_valid & o_ctrl[0]
  - o_dst_reg != 0
  - i_valid
  - (i_uses_rs & i_rs == o_dst_reg) | (i_uses_rt & i_rt == o_dst_reg)
- o_stall_id = (hazard | i_ex_stall) & ~i_flush.
- Per-edge priority, highest first:
  1. i_flush: load bubble (o_valid=0, o_ctrl=0, o_dst_reg=0; data fields don't-care, implementation drives 0). No counter increment.
  2. i_ex_stall: hold all registers unchanged. No increment, even if a hazard is present.
  3. hazard: load bubble; o_stall_cnt += 1 unless all ones (saturate).
  4. Otherwise: capture all inputs. o_valid = i_valid. If i_valid=0, o_ctrl and o_dst_reg load 0.
- Bubble state: a bubble never triggers a hazard, since o_valid=0.
- Hazard duration: a hazard lasts exactly one cycle, because the load leaves the register on the bubble edge.
- Counter:
  - i_cnt_clr sets the counter to 0 and wins over a simultaneous increment.
  - The counter is unaffected by flush and stall.
- Register $0: a load targeting register 0 never causes a stall.

Test Plan:
- Reset mid-stream: assert i_rst_n=0 asynchronously while o_valid=1 -> o_valid, o_ctrl, o_dst_reg and o_stall_cnt read 0 before the next edge.
- R-type add: i_ctrl ALU_dst=01, i_rd=7, i_valid=1 -> next cycle o_valid=1, o_dst_reg=7, o_ctrl equals input; o_stall_id stays 0.
- Load-use: LW with ALU_dst=00, i_rt=5, mem_read=1 captured, then a decode instruction with i_uses_rs=1, i_rs=5:
  - o_stall_id=1 for one cycle, bubble loaded (o_valid=0), o_stall_cnt=1.
  - On the following edge the dependent instruction is captured, and o_stall_id=0 during that cycle.
- Load to $0: same sequence with i_rt=0 -> no stall; o_stall_cnt stays 0.
- Flush vs hazard: hazard active and i_flush=1 on the same edge -> o_stall_id=0, bubble loaded, counter unchanged.
- Ex-stall hold and saturation:
  - i_ex_stall=1 for 3 cycles with a hazard present -> registers hold and counter unchanged.
  - With CNT_W=2, four hazards -> counter reads 3.
  - i_cnt_clr together with a hazard -> counter 0.
